// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, queue entry type and PC helper for the fetch stage
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular instruction queue with a registered head that holds when empty
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2,
    localparam int AW = $clog2(QDEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t  mem_q [QDEPTH];
    fetch_entry_t  head_q, head_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop_eff;

    assign pop_eff = pop && (cnt_q != '0);

    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push)    wr_d = wr_q + AW'(1);
            if (pop_eff) rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop_eff);
            // Head only moves when something remains; the word being pushed
            // becomes head when nothing older survives this cycle.
            if (cnt_d != '0) begin
                if ((cnt_q - CW'(pop_eff)) == '0) head_d = push_data;
                else                              head_d = mem_q[rd_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '{instr: NOP_INSTR, pc: '0};
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= push_data;
    end

    assign count = cnt_q;
    assign head  = head_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, request credit, response drop and redirect flush
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pcplus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_bubble_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic            outstanding_q, outstanding_d;
    logic            drop_q, drop_d;
    logic            push;
    logic [CW-1:0]   count;
    logic [CW:0]     inflight;
    fetch_entry_t    push_entry, head;

    assign inflight   = {1'b0, count} + {{CW{1'b0}}, outstanding_q};
    assign imem_req   = reset && !redirect_valid && (inflight < (CW+1)'(QDEPTH));
    assign imem_addr  = pc_q;
    assign push_entry = '{instr: imem_rdata, pc: req_pc_q};

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        push          = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h3;
            // A response still on its way must be swallowed when it lands.
            outstanding_d = outstanding_q && !imem_rvalid;
            drop_d        = outstanding_q && !imem_rvalid;
        end else begin
            if (imem_rvalid && outstanding_q) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
                push          = !drop_q;
            end
            if (imem_req) begin
                pc_d          = pc_plus4(pc_q);
                req_pc_d      = pc_q;
                outstanding_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (id_valid && id_ready),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign id_valid   = (count != '0);
    assign id_instr   = head.instr;
    assign id_pc      = head.pc;
    assign id_pcplus4 = pc_plus4(head.pc);

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_q, bubble_d, flush_q, flush_d;

    always_comb begin
        bubble_d = bubble_q + {31'b0, id_ready && !id_valid};
        flush_d  = flush_q + {31'b0, redirect_valid &&
                              (id_valid || (outstanding_q && !drop_q))};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    assign perf_bubble_cnt = bubble_q;
    assign perf_flush_cnt  = flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench: directed scenarios plus random ready/redirect against a stream model
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pcplus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int          total = 0;
    int          bad = 0;
    int          delivered = 0;
    logic [31:0] exp_pc;
    logic        delay_req = 1'b0;
    logic        held_v = 1'b0;
    logic [31:0] held_a = '0;

    fetch_stage #(.RESET_PC(RPC), .QDEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pcplus4     (id_pcplus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt(perf_bubble_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a * 32'h0001_0003 + 32'h1234_5677;
    endfunction

    // Memory answers one cycle after a request; delay_req stretches one response by a cycle.
    always @(posedge clk) begin
        if (held_v) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= memf(held_a);
            held_v      <= 1'b0;
        end else if (imem_req && delay_req) begin
            imem_rvalid <= 1'b0;
            held_v      <= 1'b1;
            held_a      <= imem_addr;
        end else begin
            imem_rvalid <= imem_req;
            imem_rdata  <= memf(imem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    // Called at a negedge: drives one cycle of inputs, scores the handshake, returns at the next negedge.
    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (id_valid && id_ready) begin
            check("stream_pc", id_pc, exp_pc);
            check("stream_instr", id_instr, memf(exp_pc));
            check("stream_pc4", id_pcplus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (rv) exp_pc = rpc & ~32'h3;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, imem_req, 1'b0);
        check({tag, "_valid"}, id_valid, 1'b0);
        check({tag, "_instr"}, id_instr, NOP_INSTR);
        check({tag, "_pc"}, id_pc, 32'h0);
        check({tag, "_pc4"}, id_pcplus4, 32'h4);
`ifdef FETCH_PERF_EN
        check({tag, "_bubble"}, perf_bubble_cnt, 32'h0);
        check({tag, "_flushcnt"}, perf_flush_cnt, 32'h0);
`endif
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 10) begin
            cyc(1'b1, 1'b0, '0);
            n++;
        end
        check(tag, imem_req, 1'b1);
    endtask

    initial begin
        reset          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exp_pc         = RPC;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");

        // Release and first-fetch latency, including PC wrap through zero.
        reset = 1'b1;
        #1;
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, RPC);
        cyc(1'b1, 1'b0, '0);
        check("lat1_valid", id_valid, 1'b0);
        cyc(1'b1, 1'b0, '0);
        check("lat2_valid", id_valid, 1'b1);
        check("lat2_pc", id_pc, RPC);
        check("lat2_addr", imem_addr, 32'h0);
        check("credit_block", imem_req, 1'b0);
        repeat (8) cyc(1'b1, 1'b0, '0);

        // Decode stall: queue fills and requests stop, then drains in order.
        repeat (10) cyc(1'b0, 1'b0, '0);
        check("stall_valid", id_valid, 1'b1);
        check("stall_req", imem_req, 1'b0);
        repeat (8) cyc(1'b1, 1'b0, '0);

        // Redirect while a (stretched) response is still in flight.
        wait_req("pre_redir_req");
        delay_req = 1'b1;
        cyc(1'b1, 1'b0, '0);
        delay_req = 1'b0;
        cyc(1'b1, 1'b1, 32'h0000_0103);
        check("redir_v0", id_valid, 1'b0);
        cyc(1'b1, 1'b0, '0);
        check("redir_v1", id_valid, 1'b0);
        cyc(1'b1, 1'b0, '0);
        check("redir_v2", id_valid, 1'b1);
        check("redir_pc", id_pc, 32'h0000_0100);
        repeat (6) cyc(1'b1, 1'b0, '0);

        // Back-to-back redirects: the second target wins.
        cyc(1'b1, 1'b1, 32'h0000_0040);
        cyc(1'b1, 1'b1, 32'h0000_0080);
        check("bb_v0", id_valid, 1'b0);
        cyc(1'b1, 1'b0, '0);
        check("bb_v1", id_valid, 1'b0);
        cyc(1'b1, 1'b0, '0);
        check("bb_v2", id_valid, 1'b1);
        check("bb_pc", id_pc, 32'h0000_0080);
        repeat (4) cyc(1'b1, 1'b0, '0);

        // Random decode back-pressure and redirects.
        delivered = 0;
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
        end
        check("progress", delivered > 40, 1'b1);

        // Reset mid-stream with a response arriving; it must be ignored after release.
        wait_req("pre_rst_req");
        cyc(1'b1, 1'b0, '0);
        check("stray_pending", imem_rvalid, 1'b1);
        #1 reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        reset    = 1'b1;
        exp_pc   = RPC;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rst_lat1", id_valid, 1'b0);
        cyc(1'b1, 1'b0, '0);
        check("rst_lat2", id_valid, 1'b1);
        check("rst_pc", id_pc, RPC);
        repeat (6) cyc(1'b1, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
